// File: rtl/bht_gshare_predictor.sv
// Branch direction predictor: a table of 2^IDX_W saturating counters indexed
// either by PC bits (bimodal) or by PC bits XOR global history (gshare).
// After reset the table is swept to weakly-not-taken one entry per cycle;
// prediction is registered (latency 1), update is a same-cycle read-modify-write.
module bht_gshare_predictor #(
   parameter int PC_W   = 32,
   parameter int IDX_W  = 10,
   parameter int CTR_W  = 2,
   parameter int HIST_W = 10,
   parameter int MODE   = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_ready,
   input  logic              i_pred_req,
   input  logic [PC_W-1:0]   i_pred_pc,
   output logic              o_pred_valid,
   output logic              o_pred_taken,
   output logic [CTR_W-1:0]  o_pred_ctr,
   output logic [HIST_W-1:0] o_pred_hist,
   input  logic              i_upd_valid,
   input  logic [PC_W-1:0]   i_upd_pc,
   input  logic [HIST_W-1:0] i_upd_hist,
   input  logic              i_upd_taken
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_init_idx;
   logic                w_init_last;
   logic                r_ready;
   logic [HIST_W-1:0]   r_ghr;
   logic [CTR_W-1:0]    r_table [2**IDX_W];

   logic                r_pred_valid;
   logic                r_pred_taken;
   logic [CTR_W-1:0]    r_pred_ctr;
   logic [HIST_W-1:0]   r_pred_hist;

   logic [IDX_W-1:0]    w_pidx;
   logic [IDX_W-1:0]    w_uidx;
   logic [CTR_W-1:0]    w_pred_rd;
   logic [CTR_W-1:0]    w_upd_rd;
   logic [CTR_W-1:0]    w_upd_nxt;
   logic                w_pred_fire;
   logic                w_upd_fire;
   logic                w_unused;

   // Saturating +/-1 step: never wraps past 0 or the all-ones maximum.
   function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic up);
      if (up) return (c == CTR_MAX) ? c : c + 1'b1;
      else    return (c == '0)      ? c : c - 1'b1;
   endfunction

   // Predict side hashes with the live GHR; update side with the history captured at predict time.
   assign w_pidx = i_pred_pc[IDX_W+1:2] ^ ((MODE != 0) ? IDX_W'(r_ghr)      : '0);
   assign w_uidx = i_upd_pc[IDX_W+1:2]  ^ ((MODE != 0) ? IDX_W'(i_upd_hist) : '0);

   assign w_pred_rd   = r_table[w_pidx];
   assign w_upd_rd    = r_table[w_uidx];
   assign w_upd_nxt   = sat_step(w_upd_rd, i_upd_taken);
   assign w_pred_fire = r_ready & i_pred_req;
   assign w_upd_fire  = r_ready & i_upd_valid;

   // PC bits outside the index field are intentionally ignored.
   assign w_unused = ^{i_pred_pc[PC_W-1:IDX_W+2], i_pred_pc[1:0],
                       i_upd_pc[PC_W-1:IDX_W+2],  i_upd_pc[1:0]};

   // Next-state logic: leave INIT once the last entry has been written.
   always_comb begin
      w_state_nxt = r_state;
      w_init_last = (r_init_idx == '1);
      if (r_state == S_INIT && w_init_last) w_state_nxt = S_RUN;
   end

   // State register, sweep pointer and ready flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_INIT;
         r_init_idx <= '0;
         r_ready    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
            if (w_init_last) r_ready <= 1'b1;
         end
      end
   end

   // Counter table: init sweep writes WNT; in RUN a resolved branch commits its saturated count.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (r_state == S_INIT) r_table[r_init_idx] <= CTR_WNT;
         else if (w_upd_fire)   r_table[w_uidx]     <= w_upd_nxt;
      end
   end

   // Global history shifts in each resolved outcome (kept in both modes).
   always_ff @(posedge i_clk) begin
      if (i_rst)           r_ghr <= '0;
      else if (w_upd_fire) r_ghr <= HIST_W'({r_ghr, i_upd_taken});
   end

   // Registered prediction; table read is read-first against a same-edge update.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_ctr   <= '0;
         r_pred_hist  <= '0;
      end else begin
         r_pred_valid <= w_pred_fire;
         if (w_pred_fire) begin
            r_pred_ctr   <= w_pred_rd;
            r_pred_taken <= w_pred_rd[CTR_W-1];
            r_pred_hist  <= r_ghr;
         end
      end
   end

   assign o_ready      = r_ready;
   assign o_pred_valid = r_pred_valid;
   assign o_pred_taken = r_pred_taken;
   assign o_pred_ctr   = r_pred_ctr;
   assign o_pred_hist  = r_pred_hist;

endmodule

// File: tb/tb_bht_gshare_predictor.sv
// Directed bench: a bimodal (u0) and a gshare (u1) instance share one stimulus
// stream; expected values are hand-computed for each instance.
module tb_bht_gshare_predictor;

   logic        clk = 1'b0;
   logic        rst, pred_req, upd_valid, upd_taken;
   logic [31:0] pred_pc, upd_pc;
   logic [9:0]  upd_hist;

   logic       rdy0, pv0, pt0, rdy1, pv1, pt1;
   logic [1:0] ctr0, ctr1;
   logic [9:0] hist0, hist1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bht_gshare_predictor #(.PC_W(32), .IDX_W(10), .CTR_W(2), .HIST_W(10), .MODE(0)) u0 (
      .i_clk(clk), .i_rst(rst), .o_ready(rdy0),
      .i_pred_req(pred_req), .i_pred_pc(pred_pc),
      .o_pred_valid(pv0), .o_pred_taken(pt0), .o_pred_ctr(ctr0), .o_pred_hist(hist0),
      .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_hist(upd_hist), .i_upd_taken(upd_taken));

   bht_gshare_predictor #(.PC_W(32), .IDX_W(10), .CTR_W(2), .HIST_W(10), .MODE(1)) u1 (
      .i_clk(clk), .i_rst(rst), .o_ready(rdy1),
      .i_pred_req(pred_req), .i_pred_pc(pred_pc),
      .o_pred_valid(pv1), .o_pred_taken(pt1), .o_pred_ctr(ctr1), .o_pred_hist(hist1),
      .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_hist(upd_hist), .i_upd_taken(upd_taken));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic predict(input logic [31:0] pc);
      pred_req = 1'b1; pred_pc = pc;
      tick();
      pred_req = 1'b0;
   endtask

   task automatic test_reset;
      int cnt;
      logic seen;
      rst = 1'b1; pred_req = 1'b0; pred_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_hist = '0; upd_taken = 1'b0;
      tick();
      n_cmp++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", rdy0); end
      n_cmp++; if (pv0 !== 1'b0 || pv1 !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b/%b want 0/0", pv0, pv1); end
      n_cmp++; if (ctr0 !== 2'd0 || hist1 !== 10'd0) begin n_err++; $display("FAIL rst_data ctr %h hist %h want 0/0", ctr0, hist1); end
      rst = 1'b0; pred_req = 1'b1; pred_pc = 32'h40;
      cnt = 0; seen = 1'b0;
      while (!rdy0 && cnt < 1100) begin
         tick(); cnt++;
         if (pv0 || pv1) seen = 1'b1;
      end
      pred_req = 1'b0;
      n_cmp++; if (cnt !== 1024) begin n_err++; $display("FAIL init_cycles got %0d want 1024", cnt); end
      n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL init_ready_u1 got %b want 1", rdy1); end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL init_valid got %b want 0", seen); end
   endtask

   task automatic test_predict_init;
      predict(32'h40);
      n_cmp++; if (pv0 !== 1'b1 || ctr0 !== 2'b01 || pt0 !== 1'b0) begin n_err++; $display("FAIL pred_init_u0 got v%b c%b t%b want v1 c01 t0", pv0, ctr0, pt0); end
      n_cmp++; if (pv1 !== 1'b1 || ctr1 !== 2'b01 || hist1 !== 10'h0) begin n_err++; $display("FAIL pred_init_u1 got v%b c%b h%h want v1 c01 h000", pv1, ctr1, hist1); end
      tick();
      n_cmp++; if (pv0 !== 1'b0 || ctr0 !== 2'b01) begin n_err++; $display("FAIL pred_hold got v%b c%b want v0 c01", pv0, ctr0); end
   endtask

   task automatic test_gshare;
      upd_valid = 1'b1; upd_pc = 32'h58; upd_hist = 10'h0; upd_taken = 1'b1;
      tick(); tick();
      upd_taken = 1'b0;
      tick();
      upd_valid = 1'b0;
      predict(32'h40);
      n_cmp++; if (hist1 !== 10'h006 || hist0 !== 10'h006) begin n_err++; $display("FAIL gs_hist got %h/%h want 006/006", hist0, hist1); end
      n_cmp++; if (ctr1 !== 2'b10 || pt1 !== 1'b1) begin n_err++; $display("FAIL gs_ctr_u1 got c%b t%b want c10 t1", ctr1, pt1); end
      n_cmp++; if (ctr0 !== 2'b01 || pt0 !== 1'b0) begin n_err++; $display("FAIL gs_ctr_u0 got c%b t%b want c01 t0", ctr0, pt0); end
   endtask

   task automatic test_read_first;
      pred_req = 1'b1; pred_pc = 32'h80;
      upd_valid = 1'b1; upd_pc = 32'h80; upd_hist = 10'h006; upd_taken = 1'b1;
      tick();
      pred_req = 1'b0; upd_valid = 1'b0;
      n_cmp++; if (ctr0 !== 2'b01 || ctr1 !== 2'b01) begin n_err++; $display("FAIL rf_ctr got %b/%b want 01/01", ctr0, ctr1); end
      n_cmp++; if (hist1 !== 10'h006) begin n_err++; $display("FAIL rf_hist got %h want 006", hist1); end
      predict(32'h80);
      n_cmp++; if (ctr0 !== 2'b10) begin n_err++; $display("FAIL rf_commit_u0 got %b want 10", ctr0); end
      predict(32'hAC);
      n_cmp++; if (ctr1 !== 2'b10 || hist1 !== 10'h00D) begin n_err++; $display("FAIL rf_commit_u1 got c%b h%h want c10 h00d", ctr1, hist1); end
   endtask

   task automatic test_saturate;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_hist = 10'h0; upd_taken = 1'b1;
      repeat (3) tick();
      upd_valid = 1'b0;
      predict(32'h40);
      n_cmp++; if (ctr0 !== 2'b11 || pt0 !== 1'b1 || hist0 !== 10'h06F) begin n_err++; $display("FAIL sat_hi_u0 got c%b t%b h%h want c11 t1 h06f", ctr0, pt0, hist0); end
      predict(32'h1FC);
      n_cmp++; if (ctr1 !== 2'b11 || pt1 !== 1'b1) begin n_err++; $display("FAIL sat_hi_u1 got c%b t%b want c11 t1", ctr1, pt1); end
      upd_valid = 1'b1; upd_taken = 1'b0;
      repeat (4) tick();
      upd_valid = 1'b0;
      predict(32'h40);
      n_cmp++; if (ctr0 !== 2'b00 || pt0 !== 1'b0 || hist0 !== 10'h2F0) begin n_err++; $display("FAIL sat_lo_u0 got c%b t%b h%h want c00 t0 h2f0", ctr0, pt0, hist0); end
      predict(32'hB80);
      n_cmp++; if (ctr1 !== 2'b00 || pt1 !== 1'b0) begin n_err++; $display("FAIL sat_lo_u1 got c%b t%b want c00 t0", ctr1, pt1); end
   endtask

   task automatic test_reset_mid_init;
      int cnt;
      int bad;
      logic early;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      upd_valid = 1'b1; upd_pc = 32'h0; upd_hist = 10'h0; upd_taken = 1'b1;
      pred_req = 1'b1; pred_pc = 32'h0;
      early = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (rdy0 || rdy1 || pv0 || pv1) early = 1'b1;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL mid_early got %b want 0", early); end
      n_cmp++; if (rdy0 !== 1'b0 || ctr0 !== 2'b00 || hist0 !== 10'h0) begin n_err++; $display("FAIL mid_rst got r%b c%b h%h want r0 c00 h000", rdy0, ctr0, hist0); end
      cnt = 0; early = 1'b0;
      while (!rdy0 && cnt < 1100) begin
         tick(); cnt++;
         if (pv0 || pv1) early = 1'b1;
      end
      upd_valid = 1'b0; pred_req = 1'b0;
      n_cmp++; if (cnt !== 1024) begin n_err++; $display("FAIL mid_cycles got %0d want 1024", cnt); end
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", early); end
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         predict(32'(i) << 2);
         if (pv0 !== 1'b1 || ctr0 !== 2'b01 || ctr1 !== 2'b01 || hist1 !== 10'h0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL mid_sweep got %0d bad entries want 0", bad); end
   endtask

   initial begin
      test_reset();
      test_predict_init();
      test_gshare();
      test_read_first();
      test_saturate();
      test_reset_mid_init();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
